xgcd_job_scheduler: RTL and testbench

//  APB-programmable job scheduler for the two XGCD datapaths (255-bit, 1279-bit units).

---
 rtl/xgcd_job_scheduler.sv | 160 ++++++++++++++++
 tb/tb_xgcd_job_scheduler.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/xgcd_job_scheduler.sv
// xgcd_job_scheduler: APB job queue dispatching to the 255/1279 XGCD units with a completion FIFO and IRQ
module xgcd_job_scheduler #(
  parameter int QUEUE_DEPTH = 4,
  parameter int TAG_W = 4,
  parameter int TMO_W = 16
) (
  input  logic        clk_in_system,
  input  logic        reset,
  input  logic [7:0]  PADDR,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        start_255,
  output logic        start_1279,
  input  logic        done_255,
  input  logic        done_1279,
  output logic        irq
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  typedef enum logic [1:0] {IDLE, START, RUN, CMPL} state_t;
  logic             acc_wr, acc_rd, enable_q, irq_q, unused_ok;
  logic [5:0]       addr;
  logic [TMO_W-1:0] tmo_q;
  logic [1:0]       irq_en_q, irq_stat_q, irq_stat_d;
  logic [TAG_W:0]   sq_mem_q [QUEUE_DEPTH];
  logic [TAG_W+1:0] cq_mem_q [QUEUE_DEPTH];
  logic [AW-1:0]    sq_wr_q, sq_rd_q, cq_wr_q, cq_rd_q;
  logic [AW:0]      sq_cnt_q, cq_cnt_q;
  state_t           state_q [2];
  state_t           state_d [2];
  logic [TMO_W-1:0] timer_q [2];
  logic [TAG_W-1:0] tag_q [2];
  logic [1:0]       tmo_flag_q, done, busy, expire, push, issue_u;
  logic             sub_wr, sub_push, sub_drop, flush, issue, cq_pop, cq_push, sq_full, sq_empty, cq_empty;
  logic [TAG_W:0]   head;
  logic [TAG_W+1:0] cq_entry, cq_head;
  logic [AW+1:0]    load;
  logic [31:0]      status, cmpl_rd;
  assign addr = PADDR[7:2];
  assign unused_ok = ^{PADDR[1:0], PWDATA};
  assign acc_wr = PSEL & PENABLE & PWRITE;
  assign acc_rd = PSEL & PENABLE & ~PWRITE;
  assign done = {done_1279, done_255};
  assign sub_wr = acc_wr && addr == 6'h2;
  assign sq_full = sq_cnt_q == (AW+1)'(QUEUE_DEPTH);
  assign sq_empty = sq_cnt_q == '0;
  assign cq_empty = cq_cnt_q == '0;
  assign sub_push = sub_wr & ~sq_full;
  assign sub_drop = sub_wr & sq_full;
  assign flush = acc_wr && addr == 6'h0 && PWDATA[1];
  assign head = sq_mem_q[sq_rd_q];
  assign cq_head = cq_mem_q[cq_rd_q];
  for (genvar u = 0; u < 2; u++) begin : g_unit
    assign busy[u] = state_q[u] != IDLE;
    assign expire[u] = tmo_q != '0 && timer_q[u] == tmo_q - 1'b1;
  end
  // reserve one completion slot per busy unit so a completion push can never overflow
  assign load = (AW+2)'(cq_cnt_q) + (AW+2)'(busy[0]) + (AW+2)'(busy[1]);
  assign issue = enable_q & ~flush & ~sq_empty & ~busy[head[TAG_W]] & (load < (AW+2)'(QUEUE_DEPTH));
  assign issue_u = {issue & head[TAG_W], issue & ~head[TAG_W]};
  assign push[0] = state_q[0] == CMPL;
  assign push[1] = state_q[1] == CMPL & ~push[0];
  assign cq_push = |push;
  assign cq_entry = {tmo_flag_q[push[1]], push[1], tag_q[push[1]]};
  assign cq_pop = acc_rd && addr == 6'h3 && !cq_empty;
  assign irq_stat_d = (irq_stat_q & ~((acc_wr && addr == 6'h5) ? PWDATA[1:0] : 2'b00))
                    | {sub_drop | (cq_push & cq_entry[TAG_W+1]), cq_push};
  assign start_255 = state_q[0] == START;
  assign start_1279 = state_q[1] == START;
  assign PREADY = 1'b1;
  assign PSLVERR = sub_drop;
  assign irq = irq_q;
  // per-unit next state: issue -> start pulse -> run until done/timeout -> wait for completion push
  always_comb begin
    for (int u = 0; u < 2; u++) begin
      state_d[u] = state_q[u];
      case (state_q[u])
        IDLE:  state_d[u] = issue_u[u] ? START : IDLE;
        START: state_d[u] = RUN;
        RUN:   state_d[u] = (done[u] || expire[u]) ? CMPL : RUN;
        CMPL:  state_d[u] = push[u] ? IDLE : CMPL;
      endcase
    end
  end
  // APB read mux; CMPL returns all zeros when the completion FIFO is empty
  always_comb begin
    status = '0;
    status[3:0] = 4'(sq_cnt_q);
    status[4] = sq_full;
    status[5] = sq_empty;
    status[11:8] = 4'(cq_cnt_q);
    status[13:12] = busy;
    cmpl_rd = '0;
    cmpl_rd[TAG_W-1:0] = cq_head[TAG_W-1:0];
    cmpl_rd[8] = cq_head[TAG_W];
    cmpl_rd[9] = cq_head[TAG_W+1];
    cmpl_rd[31] = 1'b1;
    PRDATA = '0;
    if (acc_rd)
      case (addr)
        6'h0:    PRDATA = {31'b0, enable_q};
        6'h1:    PRDATA = status;
        6'h3:    PRDATA = cq_empty ? '0 : cmpl_rd;
        6'h4:    PRDATA = 32'(tmo_q);
        6'h5:    PRDATA = {30'b0, irq_stat_q};
        6'h6:    PRDATA = {30'b0, irq_en_q};
        default: PRDATA = '0;
      endcase
  end
  // registers, both FIFOs and unit state
  always_ff @(posedge clk_in_system) begin
    if (reset) begin
      enable_q <= 1'b0;
      tmo_q <= '0;
      irq_en_q <= '0;
      irq_stat_q <= '0;
      irq_q <= 1'b0;
      sq_wr_q <= '0;
      sq_rd_q <= '0;
      sq_cnt_q <= '0;
      cq_wr_q <= '0;
      cq_rd_q <= '0;
      cq_cnt_q <= '0;
      tmo_flag_q <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        sq_mem_q[i] <= '0;
        cq_mem_q[i] <= '0;
      end
      for (int u = 0; u < 2; u++) begin
        state_q[u] <= IDLE;
        timer_q[u] <= '0;
        tag_q[u] <= '0;
      end
    end else begin
      if (acc_wr && addr == 6'h0) enable_q <= PWDATA[0];
      if (acc_wr && addr == 6'h4) tmo_q <= PWDATA[TMO_W-1:0];
      if (acc_wr && addr == 6'h6) irq_en_q <= PWDATA[1:0];
      irq_stat_q <= irq_stat_d;
      irq_q <= |(irq_stat_q & irq_en_q);
      if (sub_push) sq_mem_q[sq_wr_q] <= {PWDATA[0], PWDATA[8 +: TAG_W]};
      sq_wr_q <= flush ? '0 : sq_wr_q + AW'(sub_push);
      sq_rd_q <= flush ? '0 : sq_rd_q + AW'(issue);
      sq_cnt_q <= flush ? '0 : sq_cnt_q + (AW+1)'(sub_push) - (AW+1)'(issue);
      if (cq_push) cq_mem_q[cq_wr_q] <= cq_entry;
      cq_wr_q <= cq_wr_q + AW'(cq_push);
      cq_rd_q <= cq_rd_q + AW'(cq_pop);
      cq_cnt_q <= cq_cnt_q + (AW+1)'(cq_push) - (AW+1)'(cq_pop);
      for (int u = 0; u < 2; u++) begin
        state_q[u] <= state_d[u];
        if (issue_u[u]) tag_q[u] <= head[TAG_W-1:0];
        timer_q[u] <= state_q[u] == START ? '0 : state_q[u] == RUN ? timer_q[u] + 1'b1 : timer_q[u];
        if (state_q[u] == RUN && state_d[u] == CMPL) tmo_flag_q[u] <= ~done[u];
      end
    end
  end
endmodule

// File: tb/tb_xgcd_job_scheduler.sv
// tb_xgcd_job_scheduler: directed checks of dispatch, completion, timeout, backpressure and reset
module tb_xgcd_job_scheduler;
  logic        clk = 1'b0;
  logic        reset, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic        start_255, start_1279, done_255, done_1279, irq;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA, PRDATA, r;
  logic        e;
  int          cyc = 0, total = 0, passed = 0, acc_cyc = 0;

  xgcd_job_scheduler dut (
    .clk_in_system(clk), .reset(reset), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .start_255(start_255), .start_1279(start_1279), .done_255(done_255), .done_1279(done_1279),
    .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic apb(input logic w, input logic [7:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic err);
    @(negedge clk);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d;
    @(negedge clk);
    PENABLE = 1'b1;
    #2;
    rd = PRDATA; err = PSLVERR; acc_cyc = cyc;
    @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic do_reset();
    PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0; done_255 = 0; done_1279 = 0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_resp(input int n, output int starts);
    int due = -1;
    starts = 0;
    for (int i = 0; i < n; i++) begin
      done_255 = (cyc == due);
      if (start_255) begin starts++; due = cyc + 3; end
      @(negedge clk);
    end
    done_255 = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if ({PREADY, PSLVERR, start_255, start_1279, irq} !== 5'b10000) $display("FAIL reset_pins got %b exp 10000", {PREADY, PSLVERR, start_255, start_1279, irq}); else passed++;
    total++; if (PRDATA !== 32'h0) $display("FAIL reset_prdata got %h exp 0", PRDATA); else passed++;
    apb(0, 8'h04, 0, r, e);
    total++; if (r !== 32'h20) $display("FAIL reset_status got %h exp 20", r); else passed++;
    apb(0, 8'h0C, 0, r, e);
    total++; if ({e, r} !== 33'h0) $display("FAIL reset_cmpl got %b/%h exp 0/0", e, r); else passed++;
    apb(0, 8'h14, 0, r, e);
    total++; if (r !== 32'h0) $display("FAIL reset_irqstat got %h exp 0", r); else passed++;
    apb(0, 8'h1C, 0, r, e);
    total++; if (r !== 32'h0) $display("FAIL unmapped_read got %h exp 0", r); else passed++;
  endtask

  task automatic test_single_job();
    int k;
    do_reset();
    apb(1, 8'h18, 32'h1, r, e);
    apb(1, 8'h00, 32'h1, r, e);
    apb(1, 8'h08, 32'h0000_0500, r, e);
    k = acc_cyc;
    for (int c = 1; c <= 14; c++) begin
      total++; if (cyc != k + c || {start_1279, start_255} !== {1'b0, c == 2}) $display("FAIL t1_start c=%0d got %b exp %b", c, {start_1279, start_255}, {1'b0, c == 2}); else passed++;
      if (c == 12) begin total++; if (irq !== 1'b0) $display("FAIL t1_irq_early got %b exp 0", irq); else passed++; end
      if (c == 13) begin total++; if (irq !== 1'b1) $display("FAIL t1_irq got %b exp 1", irq); else passed++; end
      done_255 = (c == 10);
      @(negedge clk);
    end
    done_255 = 1'b0;
    apb(0, 8'h0C, 0, r, e);
    total++; if ({e, r} !== {1'b0, 32'h8000_0005}) $display("FAIL t1_cmpl got %b/%h exp 0/80000005", e, r); else passed++;
    apb(0, 8'h0C, 0, r, e);
    total++; if (r !== 32'h0) $display("FAIL t1_cmpl_empty got %h exp 0", r); else passed++;
    apb(0, 8'h14, 0, r, e);
    total++; if (r !== 32'h1) $display("FAIL t1_irqstat got %h exp 1", r); else passed++;
    apb(1, 8'h14, 32'h1, r, e);
    @(negedge clk);
    total++; if (irq !== 1'b0) $display("FAIL t1_irq_clear got %b exp 0", irq); else passed++;
  endtask

  task automatic test_full_queue();
    do_reset();
    for (int j = 0; j < 5; j++) begin
      apb(1, 8'h08, 32'(j) << 8, r, e);
      total++; if (e !== (j == 4)) $display("FAIL t2_pslverr j=%0d got %b exp %b", j, e, j == 4); else passed++;
    end
    apb(0, 8'h04, 0, r, e);
    total++; if (r !== 32'h14) $display("FAIL t2_status got %h exp 14", r); else passed++;
    apb(0, 8'h14, 0, r, e);
    total++; if (r !== 32'h2) $display("FAIL t2_irqstat got %h exp 2", r); else passed++;
    apb(1, 8'h00, 32'h2, r, e);
    apb(0, 8'h04, 0, r, e);
    total++; if (r !== 32'h20) $display("FAIL flush_status got %h exp 20", r); else passed++;
    apb(0, 8'h00, 0, r, e);
    total++; if (r !== 32'h0) $display("FAIL flush_ctrl got %h exp 0", r); else passed++;
  endtask

  task automatic test_both_units();
    int s0, s1;
    do_reset();
    apb(1, 8'h08, 32'h0000_0100, r, e);
    apb(1, 8'h08, 32'h0000_0201, r, e);
    apb(1, 8'h00, 32'h1, r, e);
    s0 = 0; s1 = 0;
    for (int c = 1; c <= 8; c++) begin
      if (start_255) s0 = s0 * 10 + c;
      if (start_1279) s1 = s1 * 10 + c;
      done_255 = (c == 8); done_1279 = (c == 8);
      @(negedge clk);
    end
    done_255 = 0; done_1279 = 0;
    total++; if (s0 != 2 || s1 != 3) $display("FAIL t3_starts got %0d/%0d exp 2/3", s0, s1); else passed++;
    repeat (4) @(negedge clk);
    apb(0, 8'h04, 0, r, e);
    total++; if (r !== 32'h220) $display("FAIL t3_status got %h exp 220", r); else passed++;
    apb(0, 8'h0C, 0, r, e);
    total++; if (r !== 32'h8000_0001) $display("FAIL t3_first got %h exp 80000001", r); else passed++;
    apb(0, 8'h0C, 0, r, e);
    total++; if (r !== 32'h8000_0102) $display("FAIL t3_second got %h exp 80000102", r); else passed++;
  endtask

  task automatic test_timeout();
    int k;
    do_reset();
    apb(1, 8'h18, 32'h1, r, e);
    apb(1, 8'h10, 32'd20, r, e);
    apb(1, 8'h00, 32'h1, r, e);
    apb(1, 8'h08, 32'h0000_0301, r, e);
    k = acc_cyc;
    for (int c = 1; c <= 26; c++) begin
      total++; if (cyc != k + c || start_1279 !== (c == 2)) $display("FAIL t4_start c=%0d got %b exp %b", c, start_1279, c == 2); else passed++;
      if (c == 24) begin total++; if (irq !== 1'b0) $display("FAIL t4_irq_early got %b exp 0", irq); else passed++; end
      if (c == 25) begin total++; if (irq !== 1'b1) $display("FAIL t4_irq got %b exp 1", irq); else passed++; end
      @(negedge clk);
    end
    apb(0, 8'h0C, 0, r, e);
    total++; if (r !== 32'h8000_0303) $display("FAIL t4_cmpl got %h exp 80000303", r); else passed++;
    apb(0, 8'h14, 0, r, e);
    total++; if (r !== 32'h3) $display("FAIL t4_irqstat got %h exp 3", r); else passed++;
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    for (int j = 1; j <= 4; j++) apb(1, 8'h08, 32'(j) << 8, r, e);
    apb(1, 8'h00, 32'h1, r, e);
    run_resp(50, n);
    total++; if (n != 4) $display("FAIL t5_starts got %0d exp 4", n); else passed++;
    apb(1, 8'h08, 32'h0000_0500, r, e);
    run_resp(10, n);
    total++; if (n != 0) $display("FAIL t5_blocked got %0d exp 0", n); else passed++;
    apb(0, 8'h04, 0, r, e);
    total++; if (r !== 32'h401) $display("FAIL t5_status got %h exp 401", r); else passed++;
    apb(0, 8'h0C, 0, r, e);
    total++; if (r !== 32'h8000_0001) $display("FAIL t5_pop got %h exp 80000001", r); else passed++;
    run_resp(15, n);
    total++; if (n != 1) $display("FAIL t5_fifth got %0d exp 1", n); else passed++;
    apb(0, 8'h04, 0, r, e);
    total++; if (r !== 32'h420) $display("FAIL t5_status2 got %h exp 420", r); else passed++;
  endtask

  task automatic test_reset_midjob();
    do_reset();
    apb(1, 8'h00, 32'h1, r, e);
    apb(1, 8'h08, 32'h0000_0700, r, e);
    apb(1, 8'h08, 32'h0000_0800, r, e);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    done_255 = 1'b1;
    @(negedge clk);
    done_255 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      total++; if ({start_255, start_1279, irq} !== 3'b000) $display("FAIL t6_pins c=%0d got %b exp 000", c, {start_255, start_1279, irq}); else passed++;
      @(negedge clk);
    end
    apb(0, 8'h04, 0, r, e);
    total++; if (r !== 32'h20) $display("FAIL t6_status got %h exp 20", r); else passed++;
    apb(0, 8'h0C, 0, r, e);
    total++; if ({e, r} !== 33'h0) $display("FAIL t6_cmpl got %b/%h exp 0/0", e, r); else passed++;
    apb(0, 8'h14, 0, r, e);
    total++; if (r !== 32'h0) $display("FAIL t6_irqstat got %h exp 0", r); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_full_queue();
    test_both_units();
    test_timeout();
    test_backpressure();
    test_reset_midjob();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
